// File: rtl/audio_period_meter.sv
// audio_period_meter
// Measures period and high time of a signed 16-bit audio waveform by counting
// audio samples between hysteresis-qualified rising edges.
//
// Ports:
//   clk          system clock, all logic on rising edge
//   reset        synchronous, active-high
//   audio_clk_en one-cycle sample strobe; state advances only when high
//   in           signed 16-bit audio sample (read on strobe)
//   period       last measured period in samples (0 after timeout)
//   high_time    samples spent high in the last measured period
//   valid        one-cycle pulse on each measurement or timeout
//   timeout      set on timeout, cleared by the next good measurement
//   locked       high while consecutive measurements are good
module audio_period_meter #(
   parameter logic signed [15:0] HYST_HIGH   = 16'sd1000,
   parameter logic signed [15:0] HYST_LOW    = -16'sd1000,
   parameter int                 COUNT_WIDTH = 12,
   parameter int                 MAX_PERIOD  = 4095
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   audio_clk_en,
   input  logic signed [15:0]     in,
   output logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] high_time,
   output logic                   valid,
   output logic                   timeout,
   output logic                   locked
);

   localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_PERIOD);
   localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

   typedef enum logic [1:0] {ARM, SEEK, MEAS_HIGH, MEAS_LOW} state_t;

   state_t                 state;
   logic                   level;
   logic [COUNT_WIDTH-1:0] cnt;
   logic [COUNT_WIDTH-1:0] hi_cnt;

   logic rise, fall, level_nxt, at_max, measuring;

   // HYST_LOW < HYST_HIGH, so one sample can never be both a rise and a fall.
   always_comb begin
      rise      = !level && (in >= HYST_HIGH);
      fall      =  level && (in <= HYST_LOW);
      level_nxt = rise ? 1'b1 : (fall ? 1'b0 : level);
      at_max    = (cnt == MAX_CNT);
      measuring = (state == MEAS_HIGH) || (state == MEAS_LOW);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARM;
         level     <= 1'b0;
         cnt       <= '0;
         hi_cnt    <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
         locked    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (audio_clk_en) begin
            level <= level_nxt;
            // Samples since last rise, inclusive; saturates so a stuck input
            // is caught by the timeout compare below.
            if (rise)
               cnt <= ONE;
            else if (!at_max)
               cnt <= cnt + ONE;

            // Timeout wins over any edge on the same sample.
            if (measuring && at_max) begin
               period    <= '0;
               high_time <= '0;
               timeout   <= 1'b1;
               locked    <= 1'b0;
               valid     <= 1'b1;
               state     <= ARM;
            end else begin
               case (state)
                  // Leave ARM only once the post-sample level is low, so a
                  // waveform already high never yields a partial cycle.
                  ARM: if (!level_nxt) state <= SEEK;
                  SEEK: if (rise) state <= MEAS_HIGH;
                  MEAS_HIGH: if (fall) begin
                     hi_cnt <= cnt;
                     state  <= MEAS_LOW;
                  end
                  MEAS_LOW: if (rise) begin
                     period    <= cnt;
                     high_time <= hi_cnt;
                     valid     <= 1'b1;
                     timeout   <= 1'b0;
                     locked    <= 1'b1;
                     state     <= MEAS_HIGH;
                  end
                  default: state <= ARM;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_audio_period_meter.sv
module tb_audio_period_meter;
   localparam int CW   = 12;
   localparam int MAXP = 4095;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b0;
   logic signed [15:0] smp = '0;
   logic [CW-1:0] period, high_time;
   logic valid, timeout, locked;

   audio_period_meter #(.HYST_HIGH(16'sd1000), .HYST_LOW(-16'sd1000),
                        .COUNT_WIDTH(CW), .MAX_PERIOD(MAXP)) dut (
      .clk(clk), .reset(reset), .audio_clk_en(en), .in(smp),
      .period(period), .high_time(high_time), .valid(valid),
      .timeout(timeout), .locked(locked));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // Model: tracks sample indices of the last rise and fall rather than a
   // counter. mode 0 = waiting for low, 1 = waiting for first rise,
   // 2 = have rise, 3 = have rise and fall.
   int m_level = 0, m_mode = 0, m_n = 0, m_r0 = 0, m_f = 0;
   int e_period = 0, e_high = 0, e_valid = 0, e_to = 0, e_lock = 0;
   int vcount = 0, last_p = -1, last_h = -1;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input int x);
      bit rs, fl;
      e_valid = 0;
      if (r) begin
         m_level = 0; m_mode = 0;
         e_period = 0; e_high = 0; e_to = 0; e_lock = 0;
         return;
      end
      if (!e) return;
      m_n++;
      rs = (m_level == 0) && (x >= 1000);
      fl = (m_level == 1) && (x <= -1000);
      if (rs) m_level = 1;
      else if (fl) m_level = 0;
      if (m_mode >= 2 && (m_n - m_r0) >= MAXP) begin
         e_valid = 1; e_period = 0; e_high = 0; e_to = 1; e_lock = 0;
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (m_level == 0) m_mode = 1;
      end else if (rs) begin
         if (m_mode == 3) begin
            e_valid = 1; e_period = m_n - m_r0; e_high = m_f - m_r0;
            e_to = 0; e_lock = 1;
         end
         m_r0 = m_n; m_mode = 2;
      end else if (fl && m_mode == 2) begin
         m_f = m_n; m_mode = 3;
      end
   endtask

   // Checks the result of the previous edge, then applies the next inputs.
   task automatic step(input bit r, input bit e, input int x);
      @(negedge clk);
      chk("valid", int'(valid), e_valid);
      chk("period", int'(period), e_period);
      chk("high_time", int'(high_time), e_high);
      chk("timeout", int'(timeout), e_to);
      chk("locked", int'(locked), e_lock);
      if (valid) begin
         vcount++; last_p = int'(period); last_h = int'(high_time);
      end
      reset = r; en = e; smp = 16'(x);
      model_step(r, e, x);
   endtask

   // 28 low samples then 20 high per period, optional sub-threshold spikes
   // and random idle clocks between strobes.
   task automatic wave(input int np, input bit spk, input bit gap);
      int x;
      for (int p = 0; p < np; p++)
         for (int i = 0; i < 48; i++) begin
            x = (i < 28) ? -16000 : 16000;
            if (spk && i == 14) x = 800;
            if (spk && i == 38) x = -800;
            step(1'b0, 1'b1, x);
            if (gap) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, x);
         end
   endtask

   initial begin
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 16000);
      step(1'b0, 1'b0, 0);
      chk("rst_period", int'(period), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_locked", int'(locked), 0);

      // Square wave from reset: rises at 28,76,124,172 -> 3 measurements
      vcount = 0;
      wave(4, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0);
      chk("sq_nvalid", vcount, 3);
      chk("sq_period", last_p, 48);
      chk("sq_high", last_h, 20);
      chk("sq_locked", int'(locked), 1);
      chk("model_period", e_period, 48);
      chk("model_high", e_high, 20);

      // Hysteresis spikes: continuing wave, every rise measures
      vcount = 0;
      wave(3, 1'b1, 1'b0);
      step(1'b0, 1'b0, 0);
      chk("hy_nvalid", vcount, 3);
      chk("hy_period", last_p, 48);
      chk("hy_high", last_h, 20);

      // Timeout: stuck high
      vcount = 0;
      repeat (4100) step(1'b0, 1'b1, 16000);
      step(1'b0, 1'b0, 0);
      chk("to_nvalid", vcount, 1);
      chk("to_flag", int'(timeout), 1);
      chk("to_locked", int'(locked), 0);
      chk("to_period", int'(period), 0);
      chk("model_to", e_to, 1);

      // Resume: needs low then two rises
      vcount = 0;
      wave(3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0);
      chk("rs_nvalid", vcount, 2);
      chk("rs_timeout", int'(timeout), 0);
      chk("rs_period", last_p, 48);

      // Start high after reset
      step(1'b1, 1'b0, 0);
      vcount = 0;
      repeat (50) step(1'b0, 1'b1, 16000);
      chk("sh_none", vcount, 0);
      wave(3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0);
      chk("sh_nvalid", vcount, 2);
      chk("sh_high", last_h, 20);

      // Strobe gating with idle clocks
      vcount = 0;
      wave(3, 1'b0, 1'b1);
      step(1'b0, 1'b0, 0);
      chk("gt_nvalid", vcount, 3);
      chk("gt_period", last_p, 48);
      chk("gt_high", last_h, 20);

      // Reset in the middle of the low half (also with a strobe pending)
      wave(1, 1'b0, 1'b0);
      repeat (10) step(1'b0, 1'b1, -16000);
      step(1'b1, 1'b1, 16000);
      step(1'b0, 1'b0, 0);
      chk("rm_period", int'(period), 0);
      chk("rm_high", int'(high_time), 0);
      chk("rm_locked", int'(locked), 0);
      chk("rm_timeout", int'(timeout), 0);
      vcount = 0;
      wave(3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0);
      chk("rm_nvalid", vcount, 2);
      chk("rm_p", last_p, 48);
      chk("rm_h", last_h, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/audio_period_meter.md
# audio_period_meter

Measures the period and high time of a signed 16-bit audio waveform, such as a 555 VCO or astable output, by counting audio samples between hysteresis-qualified rising edges. It sits on the audio sample bus, clocked by the system clock and advanced by `audio_clk_en`. It feeds pitch-tracking logic and self-check benches, so an oscillator's output frequency can be compared against its control input.

## Interface
- `HYST_HIGH`, default 1000: signed 16-bit level; a sample `>= HYST_HIGH` classifies the waveform high.
- `HYST_LOW`, default -1000: signed 16-bit level; a sample `<= HYST_LOW` classifies it low. Must be `< HYST_HIGH`.
- `COUNT_WIDTH`, default 12: width of the sample counters and of the outputs.
- `MAX_PERIOD`, default 4095: timeout in samples. Must be `<= 2^COUNT_WIDTH - 1`.

Ports:
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `audio_clk_en` input 1: one-cycle sample strobe; all state advances only on cycles where it is high.
- `in` input signed 16: audio sample, read only when `audio_clk_en` is high.
- `period` output `COUNT_WIDTH`: last measured period in samples.
- `high_time` output `COUNT_WIDTH`: samples spent high in the last measured period.
- `valid` output 1: one-cycle pulse when `period`/`high_time` update or a timeout occurs.
- `timeout` output 1: set on timeout, cleared on the next good measurement.
- `locked` output 1: high while consecutive measurements are valid.

## Operation
- Comparator `level`:
  - Becomes 1 on a sample `>= HYST_HIGH`.
  - Becomes 0 on a sample `<= HYST_LOW`.
  - Otherwise holds its value.
  - Reset value is 0.
- Rise sample: a sample that takes `level` from 0 to 1. Fall sample: a sample that takes it from 1 to 0.
- Counter `cnt` holds the number of samples since the last rise sample, inclusive. It is set to 1 on a rise sample and increments on every other sample, saturating at `MAX_PERIOD`.
- State machine states: ARM, SEEK, MEAS_HIGH, MEAS_LOW.
  - ARM (after reset or timeout): wait until `level` is 0, then go to SEEK. A waveform that is already high at startup is therefore never measured as a partial cycle.
  - SEEK, on a rise sample: set `cnt=1`, go to MEAS_HIGH. No output.
  - MEAS_HIGH, on a fall sample: latch internal `hi_cnt <= cnt`, go to MEAS_LOW.
  - MEAS_LOW, on a rise sample, do all of the following and go to MEAS_HIGH:
    - `period <= cnt`, `high_time <= hi_cnt`.
    - `valid` pulse, `timeout <= 0`, `locked <= 1`.
    - `cnt <= 1`.
  - MEAS_HIGH or MEAS_LOW, when a sample is taken while `cnt == MAX_PERIOD`, do all of the following and go to ARM:
    - `period <= 0`, `high_time <= 0`.
    - `timeout <= 1`, `locked <= 0`, `valid` pulse.
- With rise samples at indices r0 and r1 and the fall sample at f: `period = r1 - r0` and `high_time = f - r0`.
- Simultaneous events:
  - Timeout takes priority over a rise or fall on the same sample.
  - A single sample cannot produce both a fall and a rise.
- Reset mid-measurement discards everything and returns to ARM.

## Timing
- Outputs and `level` are registered. `valid` is high for exactly one `clk` cycle, the cycle after the `audio_clk_en` cycle that carried the qualifying sample. `period`, `high_time`, `timeout` and `locked` update in that same cycle.
- `valid` never asserts on two consecutive cycles. Between strobes all outputs hold.
- Reset values:
  - `period`, `high_time` = 0.
  - `valid`, `timeout`, `locked` = 0.
  - State = ARM, `cnt` = 0, `level` = 0.
- `reset` overrides `audio_clk_en` on the same cycle.
- Minimum measurable period is 2 samples. Maximum is `MAX_PERIOD - 1` samples; a period of `MAX_PERIOD` or longer times out.

## Test plan
- Square wave from reset: repeated pattern of 20 samples at +16000 and 28 at -16000, starting low. No `valid` until the second rise. Then each rise gives `valid`, `period=48`, `high_time=20`, `locked=1`, `timeout=0`.
- Hysteresis: same wave with ±800 spikes inserted mid-half-cycle. Results must be identical to the clean wave, `period=48`, `high_time=20`.
- Timeout:
  - Lock first, then hold `in` at +16000. After 4095 samples from the last rise: one `valid`, `timeout=1`, `locked=0`, `period=0`.
  - Resume the wave. The first `valid` comes only after a fresh low, then two rises, and clears `timeout`.
- Start high: hold `in` at +16000 from reset, then apply the wave. No measurement until the signal has gone low and then risen twice.
- Strobe gating: insert random idle `clk` cycles between `audio_clk_en` pulses. Results must be unchanged, and `valid` must always land one `clk` cycle after the qualifying strobe.
- Reset mid-MEAS_LOW: assert `reset` for one cycle. All outputs read 0 the next cycle, and the first measurement after that is correct (48/20).
